l1a_stamp_fifo: RTL

Downstream of the TTC synchronizer: on each accepted L1A, stamps the trigger with a running 12-bit L1A number and the bunch crossing of the triggering event. The bunch crossing is the live `bxn_counter` corrected for L1A latency, modulo the selected LHC cycle. Entries are buffered in a small show-ahead FIFO for the DAQ readout. `l1a_cnt_reset` and `fmm_trig_stop` from the synchronizer clear the block and gate it.

---
 rtl/l1a_stamp_fifo.sv | 69 ++++++
 1 files changed

// File: rtl/l1a_stamp_fifo.sv
// l1a_stamp_fifo: stamps accepted L1As with a running number and latency-corrected BXN into a show-ahead FIFO.
// Optional macro L1A_FMM_GATE_EN: when defined, fmm_trig_stop blocks L1A acceptance.
module l1a_stamp_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  hard_rst,
    input  logic                  l1a,
    input  logic                  l1a_cnt_reset,
    input  logic                  fmm_trig_stop,
    input  logic [11:0]           bxn_counter,
    input  logic                  lhc_cycle_sel,
    input  logic [11:0]           l1a_bxn_offset,
    input  logic                  rd_en,
    output logic [11:0]           l1a_number,
    output logic [23:0]           dout,
    output logic                  dout_valid,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   fill_level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    logic [23:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  gate, accept, pop, wr;
    logic [11:0]           cyc, stamp;
`ifdef L1A_FMM_GATE_EN
    assign gate = ~fmm_trig_stop;
`else
    logic unused_fmm;
    assign unused_fmm = fmm_trig_stop;
    assign gate = 1'b1;
`endif
    assign cyc        = lhc_cycle_sel ? 12'd3564 : 12'd924;
    // the wrapped sum may exceed 12 bits, but the true result is below cyc so modulo-4096 is exact
    assign stamp      = bxn_counter >= l1a_bxn_offset ? bxn_counter - l1a_bxn_offset
                                                      : bxn_counter + cyc - l1a_bxn_offset;
    assign accept     = l1a & ~l1a_cnt_reset & gate;
    assign dout_valid = fill_level != '0;
    assign fifo_full  = fill_level[DEPTH_LOG2];
    assign pop        = rd_en & dout_valid & ~l1a_cnt_reset;
    assign wr         = accept & (~fifo_full | pop);
    assign dout       = dout_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= {l1a_number, stamp};

    always_ff @(posedge clk or negedge hard_rst) begin
        if (!hard_rst) begin
            l1a_number <= '0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else if (l1a_cnt_reset) begin
            l1a_number <= '0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (accept) l1a_number <= l1a_number + 12'd1;
            if (accept && !wr) overflow <= 1'b1;
            if (wr) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            fill_level <= fill_level + (DEPTH_LOG2+1)'(wr) - (DEPTH_LOG2+1)'(pop);
        end
    end
endmodule
